// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared state encoding and frame constants for the program loader.
//           The CSUM state exists only when PROG_LOADER_CHECKSUM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  // Frame layout: one count byte, then two bytes (high, low) per word.
  localparam int unsigned HDR_BYTES      = 1;
  localparam int unsigned BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
`ifdef PROG_LOADER_CHECKSUM_EN
    , ST_CSUM = 3'd6
`endif
  } state_e;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module  : loader_timeout
// Brief   : Inter-byte idle counter. Counts enabled cycles since the last
//           clear and flags expiry once LIMIT idle cycles have been seen.
// Revision: 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // Idle-cycle counter; holds at the terminal value until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule : loader_timeout
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Brief   : Serial program loader. Receives a count byte followed by
//           high/low byte pairs and writes 16-bit words into instruction RAM
//           while holding the CPU halted. Aborts on inter-byte timeout.
//           Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned addr_width     = 8,
  parameter int unsigned data_width     = 16,
  parameter int unsigned timeout_cycles = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [addr_width-1:0] w_addr,
  output logic [data_width-1:0] din,
  output logic                  w_en,
  output logic                  cpu_halt,
  output logic                  done,
  output logic                  err
);

  state_e                  state_q;
  logic [addr_width-1:0]   w_addr_q;
  logic [data_width-1:0]   din_q;
  logic                    w_en_q;
  logic                    cpu_halt_q;
  logic                    done_q;
  logic                    err_q;
  logic [7:0]              hi_q;
  logic [7:0]              wcnt_q;   // words still to come after the current one
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q;
`endif

  logic load_active;
  logic tmo_clr;
  logic tmo_expired;

  // The timeout only runs while a frame is in progress.
  always_comb begin
    load_active = 1'b0;
    case (state_q)
      ST_COUNT, ST_HI, ST_LO: load_active = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM:                load_active = 1'b1;
`endif
      default:                load_active = 1'b0;
    endcase
  end

  assign tmo_clr = rx_valid || !load_active;

  loader_timeout #(
    .LIMIT (timeout_cycles)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (load_active),
    .expired_o (tmo_expired)
  );

  // Frame FSM with registered RAM-write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      w_addr_q   <= '0;
      din_q      <= '0;
      w_en_q     <= 1'b0;
      cpu_halt_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hi_q       <= '0;
      wcnt_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      w_en_q <= 1'b0;
      // Address advances in the cycle following each write pulse.
      if (w_en_q) begin
        w_addr_q <= w_addr_q + addr_width'(1);
      end

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q    <= ST_COUNT;
            w_addr_q   <= '0;
            cpu_halt_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end

        ST_COUNT: begin
          if (tmo_expired) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            cpu_halt_q <= 1'b0;
          end else if (rx_valid) begin
            wcnt_q  <= rx_data;
            state_q <= ST_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end

        ST_HI: begin
          if (tmo_expired) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            cpu_halt_q <= 1'b0;
          end else if (rx_valid) begin
            hi_q    <= rx_data;
            state_q <= ST_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_q + rx_data;
`endif
          end
        end

        ST_LO: begin
          if (tmo_expired) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            cpu_halt_q <= 1'b0;
          end else if (rx_valid) begin
            din_q  <= {hi_q, rx_data};
            w_en_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q  <= sum_q + rx_data;
`endif
            if (wcnt_q == 8'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q    <= ST_CSUM;
`else
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_halt_q <= 1'b0;
`endif
            end else begin
              wcnt_q  <= wcnt_q - 8'd1;
              state_q <= ST_HI;
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (tmo_expired) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            cpu_halt_q <= 1'b0;
          end else if (rx_valid) begin
            cpu_halt_q <= 1'b0;
            if (rx_data == sum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_q    <= ST_IDLE;
          cpu_halt_q <= 1'b0;
        end
      endcase
    end
  end

  assign w_addr   = w_addr_q;
  assign din      = din_q;
  assign w_en     = w_en_q;
  assign cpu_halt = cpu_halt_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader with a write scoreboard.
//           Checksum scenarios are included when PROG_LOADER_CHECKSUM_EN is
//           defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 20;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] w_addr;
  logic [15:0]   din;
  logic          w_en;
  logic          cpu_halt;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;

  logic [23:0]   exp_q[$];
  logic [AW-1:0] exp_addr;
  logic [7:0]    csum;

  prog_loader #(
    .addr_width     (AW),
    .data_width     (16),
    .timeout_cycles (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .w_addr   (w_addr),
    .din      (din),
    .w_en     (w_en),
    .cpu_halt (cpu_halt),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wen", {8'd0, w_addr, din}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("w_addr", 32'(w_addr), 32'(e[23:16]));
        chk("din",    32'(din),    32'(e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic begin_load(input logic [7:0] c);
    pulse_start();
    exp_addr = '0;
    csum     = '0;
    send(c);
  endtask

  task automatic word(input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back({exp_addr, hi, lo});
    exp_addr = exp_addr + 8'd1;
    csum     = csum + hi + lo;
    send(hi);
    send(lo);
  endtask

  task automatic end_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    send(csum);
`endif
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"},  32'(err),  32'(e));
    chk({tag, "_halt"}, 32'(cpu_halt), 32'(h));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst = 1'b1; start = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_din",    32'(din),    0);
    chk("rst_w_en",   32'(w_en),   0);
    chk_status("rst", 1'b0, 1'b0, 1'b0);

    // rx_valid in IDLE is ignored
    rst = 1'b0;
    tick();
    wr0 = n_wr;
    send(8'h01); send(8'h12); send(8'h34);
    chk("idle_writes", 32'(n_wr - wr0), 0);
    chk_status("idle", 1'b0, 1'b0, 1'b0);

    // Basic two-word load
    pulse_start();
    chk("halt_after_start", 32'(cpu_halt), 1);
    exp_addr = '0; csum = '0;
    send(8'h01);
    word(8'h12, 8'h34);
    word(8'hAB, 8'hCD);
    end_load();
    tick();
    chk_status("basic", 1'b1, 1'b0, 1'b0);
    chk("basic_pending", 32'(exp_q.size()), 0);

    // rx_valid in DONE is ignored
    wr0 = n_wr;
    send(8'h55); send(8'h66);
    chk("done_writes", 32'(n_wr - wr0), 0);
    chk("done_hold", 32'(done), 1);

    // Start pulses in HI and LO are ignored
    begin_load(8'h01);
    word(8'h11, 8'h22);
    pulse_start();
    send(8'h33);
    pulse_start();
    exp_q.push_back({exp_addr, 8'h33, 8'h44});
    exp_addr = exp_addr + 8'd1;
    csum = csum + 8'h33 + 8'h44;
    send(8'h44);
    end_load();
    tick();
    chk_status("startign", 1'b1, 1'b0, 1'b0);
    chk("startign_pending", 32'(exp_q.size()), 0);

    // Inter-byte timeout
    wr0 = n_wr;
    begin_load(8'h00);
    send(8'h12);
    repeat (TMO - 4) tick();
    chk("tmo_early_err", 32'(err), 0);
    begin
      int k = 0;
      while (err !== 1'b1 && k < 10) begin tick(); k++; end
    end
    chk_status("tmo", 1'b0, 1'b1, 1'b0);
    chk("tmo_writes", 32'(n_wr - wr0), 0);

    // Reset mid-load
    begin_load(8'h03);
    word(8'hAA, 8'hBB);
    send(8'hCC);
    rst = 1'b1;
    tick();
    chk("midrst_w_addr", 32'(w_addr), 0);
    chk("midrst_din",    32'(din),    0);
    chk("midrst_w_en",   32'(w_en),   0);
    chk_status("midrst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Reset coinciding with the low byte: no write may follow
    wr0 = n_wr;
    begin_load(8'h00);
    send(8'h12);
    rx_data = 8'h34; rx_valid = 1'b1; rst = 1'b1;
    tick();
    rx_valid = 1'b0; rst = 1'b0;
    tick(); tick();
    chk("rstlo_writes", 32'(n_wr - wr0), 0);

    // A later frame loads from address 0
    begin_load(8'h01);
    word(8'h0F, 8'hF0);
    word(8'h5A, 8'hA5);
    end_load();
    tick();
    chk_status("reload", 1'b1, 1'b0, 1'b0);

    // Maximum frame: 256 words, address wraps
    wr0 = n_wr;
    begin_load(8'hFF);
    for (int i = 0; i < 256; i++) begin
      word(8'(i), 8'(i ^ 8'h5C));
    end
    end_load();
    tick();
    chk("wrap_writes", 32'(n_wr - wr0), 256);
    chk("wrap_w_addr", 32'(w_addr), 0);
    chk_status("wrap", 1'b1, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum
    begin_load(8'h00);
    word(8'h12, 8'h34);
    send(8'h46);
    tick();
    chk_status("csum_ok", 1'b1, 1'b0, 1'b0);
    // Bad checksum: word is still written
    wr0 = n_wr;
    begin_load(8'h00);
    word(8'h12, 8'h34);
    send(8'h47);
    tick();
    chk_status("csum_bad", 1'b0, 1'b1, 1'b0);
    chk("csum_bad_writes", 32'(n_wr - wr0), 1);
`endif

    tick();
    chk("final_pending", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_prog_loader
`default_nettype wire
